// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and defaults for the bit-serial add sequencer
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - request/result bundle for serial_add_ctrl; sub exists only with SERIAL_ADD_SUB_EN
interface serial_add_ctrl_if #(
    parameter int WIDTH = serial_add_pkg::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, input busy, done, sum, cout);
    modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/half_adder_cell.sv
// rtl/half_adder_cell.sv - single-bit half adder cell
module half_adder_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - LSB-first bit-serial adder sequencer; SERIAL_ADD_SUB_EN adds a subtract mode
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_q;
    logic               carry;
    logic               cout_q;
    logic [CNT_W-1:0]   cnt;
    logic               sub_in;
    logic               ha1_s;
    logic               ha1_c;
    logic               bit_s;
    logic               ha2_c;
    logic               fa_c;
    logic               last_bit;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_in = bus.sub;
`else
    assign sub_in = 1'b0;
`endif

    half_adder_cell u_ha1 (.a(a_sh[0]), .b(b_sh[0]), .s(ha1_s), .c(ha1_c));
    half_adder_cell u_ha2 (.a(ha1_s),   .b(carry),   .s(bit_s), .c(ha2_c));

    assign fa_c     = ha1_c | ha2_c;
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = RUN;
            RUN:     if (last_bit)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B at load and seed the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_sh  <= bus.a;
                        b_sh  <= bus.b ^ {WIDTH{sub_in}};
                        carry <= sub_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    sum_q <= {bit_s, sum_q[WIDTH-1:1]};
                    carry <= fa_c;
                    cnt   <= cnt + 1'b1;
                    if (last_bit) cout_q <= fa_c;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state == RUN);
    assign bus.done = (state == DONE);
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - scoreboard bench for serial_add_ctrl
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [8:0] sb[$];

    serial_add_ctrl_if #(.WIDTH(8)) bus ();

    serial_add_ctrl #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        checks++;
        if (bus.busy && bus.done) begin
            errors++;
            $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", bus.busy, bus.done);
        end
    end

    function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        if (sv) return {1'b0, av} + {1'b0, ~bv} + 9'd1;
        return {1'b0, av} + {1'b0, bv};
    endfunction

    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic sv);
        bus.a = av;
        bus.b = bv;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sv;
`endif
        bus.start = 1'b1;
        sb.push_back(model(av, bv, sv));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output bit got, output int cyc, output int busy_cyc);
        got = 0;
        cyc = 0;
        busy_cyc = 0;
        while (!got && cyc < 40) begin
            if (bus.busy) busy_cyc++;
            @(negedge clk);
            cyc++;
            if (bus.done) got = 1;
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_add();
        bit got; int cyc; int bcyc; logic [8:0] exp;
        launch(8'h35, 8'h4A, 1'b0);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_after_accept: busy=%b required 1", bus.busy);
        end
        wait_done(got, cyc, bcyc);
        exp = sb.pop_front();
        checks++;
        if (!got || cyc != 8 || bcyc != 8) begin
            errors++;
            $display("FAIL basic_latency: got=%0d cycles=%0d busy_cycles=%0d required 8/8", got, cyc, bcyc);
        end
        checks++;
        if ({bus.cout, bus.sum} !== exp || exp !== 9'h07F) begin
            errors++;
            $display("FAIL basic_result: cout=%b sum=%h required cout=0 sum=7f", bus.cout, bus.sum);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_strobe: done=%b required 0", bus.done);
        end
    endtask

    task automatic test_overflow();
        bit got; int cyc; int bcyc; logic [8:0] exp;
        launch(8'hFF, 8'h01, 1'b0);
        cyc = 0;
        got = 0;
        while (!got && cyc < 40) begin
            bus.a = 8'($urandom);
            bus.b = 8'($urandom);
            @(negedge clk);
            cyc++;
            if (bus.done) got = 1;
        end
        exp = sb.pop_front();
        checks++;
        if (!got || {bus.cout, bus.sum} !== exp) begin
            errors++;
            $display("FAIL overflow_result: got=%0d cout=%b sum=%h required cout=1 sum=00", got, bus.cout, bus.sum);
        end
        bcyc = 0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n = 0; int cyc = 0; int prev = -1; logic [8:0] exp;
        logic [7:0] ra; logic [7:0] rb;
        bus.start = 1'b1;
        while (n < 4 && cyc < 200) begin
            if (!bus.busy && !bus.done) begin
                ra = 8'($urandom);
                rb = 8'($urandom);
                bus.a = ra;
                bus.b = rb;
                sb.push_back(model(ra, rb, 1'b0));
            end else if (bus.busy) begin
                bus.a = 8'($urandom);
                bus.b = 8'($urandom);
            end
            if (bus.done) begin
                exp = sb.pop_front();
                checks++;
                if ({bus.cout, bus.sum} !== exp) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: cout=%b sum=%h required cout=%b sum=%h",
                             n, bus.cout, bus.sum, exp[8], exp[7:0]);
                end
                if (prev >= 0) begin
                    checks++;
                    if (cyc - prev != 10) begin
                        errors++;
                        $display("FAIL b2b_interval_%0d: interval=%0d required 10", n, cyc - prev);
                    end
                end
                prev = cyc;
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checks++;
        if (n != 4 || sb.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: results=%0d pending=%0d required 4/0", n, sb.size());
        end
        sb.delete();
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done || bus.busy) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL b2b_extra_activity: active_cycles=%0d required 0", n);
        end
    endtask

    task automatic test_reset_mid_run();
        bit got; int cyc; int bcyc; logic [8:0] exp;
        launch(8'hA5, 8'h5A, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        void'(sb.pop_back());
        checks++;
        if ({bus.busy, bus.done, bus.sum, bus.cout} !== 11'd0) begin
            errors++;
            $display("FAIL midrun_reset: busy=%b done=%b sum=%h cout=%b required all 0",
                     bus.busy, bus.done, bus.sum, bus.cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(8'h20, 8'h22, 1'b0);
        wait_done(got, cyc, bcyc);
        exp = sb.pop_front();
        checks++;
        if (!got || {bus.cout, bus.sum} !== exp || cyc != 8) begin
            errors++;
            $display("FAIL midrun_recover: got=%0d cycles=%0d cout=%b sum=%h required 8 cycles cout=0 sum=42",
                     got, cyc, bus.cout, bus.sum);
        end
        @(negedge clk);
    endtask

    task automatic test_hold();
        bit got; int cyc; int bcyc; logic [8:0] exp;
        launch(8'h12, 8'h34, 1'b0);
        wait_done(got, cyc, bcyc);
        exp = sb.pop_front();
        checks++;
        if (!got || {bus.cout, bus.sum} !== exp) begin
            errors++;
            $display("FAIL hold_result: got=%0d cout=%b sum=%h required cout=0 sum=46", got, bus.cout, bus.sum);
        end
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (bus.sum !== 8'h46 || bus.cout !== 1'b0 || bus.done !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle: sum=%h cout=%b done=%b required 46/0/0", bus.sum, bus.cout, bus.done);
            end
        end
    endtask

`ifdef SERIAL_ADD_SUB_EN
    task automatic test_subtract();
        bit got; int cyc; int bcyc; logic [8:0] exp;
        launch(8'h10, 8'h01, 1'b1);
        wait_done(got, cyc, bcyc);
        exp = sb.pop_front();
        checks++;
        if (!got || {bus.cout, bus.sum} !== 9'h10F || exp !== 9'h10F) begin
            errors++;
            $display("FAIL sub_no_borrow: cout=%b sum=%h required cout=1 sum=0f", bus.cout, bus.sum);
        end
        @(negedge clk);
        launch(8'h01, 8'h02, 1'b1);
        wait_done(got, cyc, bcyc);
        exp = sb.pop_front();
        checks++;
        if (!got || {bus.cout, bus.sum} !== 9'h0FF || exp !== 9'h0FF) begin
            errors++;
            $display("FAIL sub_borrow: cout=%b sum=%h required cout=0 sum=ff", bus.cout, bus.sum);
        end
        @(negedge clk);
        bus.sub = 1'b0;
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = 1'b0;
`endif
        @(negedge clk);
        test_reset();
        test_basic_add();
        test_overflow();
        test_back_to_back();
        test_reset_mid_run();
        test_hold();
`ifdef SERIAL_ADD_SUB_EN
        test_subtract();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
